spi_req_arbiter: RTL and testbench

SPI_REQ_ARBITER -- requirements
Module: spi_req_arbiter

---
 rtl/spi_pkg.sv | 13 +
 rtl/spi_timeout_cnt.sv | 26 ++
 rtl/spi_req_arbiter.sv | 135 +++++++++++++
 tb/tb_spi_req_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and sizes for the two-requester SPI arbiter.
package spi_pkg;
    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 8;
    localparam int CNT_W   = 8;

    typedef enum logic [2:0] {IDLE, ARB, LAUNCH, WAIT, DONE} state_t;

    function automatic logic [NUM_REQ-1:0] owner_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction
endpackage

// File: rtl/spi_timeout_cnt.sv
// WAIT-state watchdog: counts enabled cycles and flags the last allowed one.
module spi_timeout_cnt import spi_pkg::*; #(
    parameter int TIMEOUT = 64
) (
    input  logic CLK,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear)       cnt_d = '0;
        else if (enable) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // Asserted during the TIMEOUT-th WAIT cycle, so WAIT lasts at most TIMEOUT cycles.
    assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));
endmodule

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one SPI three-wire engine between two requesters.
module spi_req_arbiter import spi_pkg::*; #(
    parameter int TIMEOUT = 64
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic [NUM_REQ-1:0]  req,
    input  logic [NUM_REQ-1:0]  wr,
    input  logic [ADDR_W-1:0]   addr0,
    input  logic [ADDR_W-1:0]   addr1,
    input  logic [DATA_W-1:0]   wdata0,
    input  logic [DATA_W-1:0]   wdata1,
    output logic [NUM_REQ-1:0]  grant,
    output logic [NUM_REQ-1:0]  done,
    output logic                err,
    output logic [DATA_W-1:0]   rdata,
    output logic                GO,
    output logic                spi_wr,
    output logic [ADDR_W-1:0]   spi_addr,
    output logic [DATA_W-1:0]   spi_wdata,
    input  logic                ORDY,
    input  logic [DATA_W-1:0]   spi_rdata
);
    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d, done_q, done_d;
    logic                err_q, err_d, go_q, go_d, spi_wr_q, spi_wr_d;
    logic                owner_q, owner_d, ptr_q, ptr_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d, spi_wdata_q, spi_wdata_d;
    logic [ADDR_W-1:0]   spi_addr_q, spi_addr_d;
    logic                win, cnt_clr, cnt_en, expired;

    // Pointer breaks ties only; a lone requester wins outright.
    assign win = (req == 2'b11) ? ptr_q : ~req[0];

    spi_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_cnt (
        .CLK     (CLK),
        .reset   (reset),
        .clear   (cnt_clr),
        .enable  (cnt_en),
        .expired (expired)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        done_d      = '0;
        err_d       = err_q;
        rdata_d     = rdata_q;
        go_d        = 1'b0;
        spi_wr_d    = spi_wr_q;
        spi_addr_d  = spi_addr_q;
        spi_wdata_d = spi_wdata_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        case (state_q)
            IDLE: if (|req) state_d = ARB;
            ARB: begin
                if (|req) begin
                    owner_d     = win;
                    grant_d     = owner_onehot(win);
                    spi_wr_d    = wr[win];
                    spi_addr_d  = win ? addr1 : addr0;
                    spi_wdata_d = win ? wdata1 : wdata0;
                    go_d        = 1'b1;
                    state_d     = LAUNCH;
                end else begin
                    state_d = IDLE;
                end
            end
            LAUNCH: begin
                cnt_clr = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_en = 1'b1;
                if (ORDY) begin
                    rdata_d = spi_wr_q ? '0 : spi_rdata;
                    err_d   = 1'b0;
                    done_d  = owner_onehot(owner_q);
                    state_d = DONE;
                end else if (expired) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    done_d  = owner_onehot(owner_q);
                    state_d = DONE;
                end
            end
            DONE: begin
                grant_d = '0;
                ptr_d   = ~owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            done_q      <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            go_q        <= 1'b0;
            spi_wr_q    <= 1'b0;
            spi_addr_q  <= '0;
            spi_wdata_q <= '0;
            owner_q     <= 1'b0;
            ptr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            go_q        <= go_d;
            spi_wr_q    <= spi_wr_d;
            spi_addr_q  <= spi_addr_d;
            spi_wdata_q <= spi_wdata_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign GO        = go_q;
    assign spi_wr    = spi_wr_q;
    assign spi_addr  = spi_addr_q;
    assign spi_wdata = spi_wdata_q;
endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed bench: main instance at default TIMEOUT, second instance at TIMEOUT=8.
module tb_spi_req_arbiter;
    logic       CLK = 1'b0;
    logic       reset;
    logic [1:0] req, req_t, wr;
    logic [6:0] addr0, addr1;
    logic [7:0] wdata0, wdata1, spi_rdata;
    logic       ORDY;

    logic [1:0] grant, done, t_grant, t_done;
    logic       err, GO, spi_wr, t_err, t_GO, t_spi_wr;
    logic [7:0] rdata, spi_wdata, t_rdata, t_spi_wdata;
    logic [6:0] spi_addr, t_spi_addr;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    spi_req_arbiter dut (
        .CLK(CLK), .reset(reset), .req(req), .wr(wr), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .grant(grant), .done(done), .err(err),
        .rdata(rdata), .GO(GO), .spi_wr(spi_wr), .spi_addr(spi_addr),
        .spi_wdata(spi_wdata), .ORDY(ORDY), .spi_rdata(spi_rdata)
    );

    spi_req_arbiter #(.TIMEOUT(8)) u_to (
        .CLK(CLK), .reset(reset), .req(req_t), .wr(wr), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .grant(t_grant), .done(t_done), .err(t_err),
        .rdata(t_rdata), .GO(t_GO), .spi_wr(t_spi_wr), .spi_addr(t_spi_addr),
        .spi_wdata(t_spi_wdata), .ORDY(ORDY), .spi_rdata(spi_rdata)
    );

    task automatic test_reset();
        reset = 1'b0; req = 2'b11; req_t = 2'b00; wr = 2'b00; ORDY = 1'b0;
        addr0 = 7'h00; addr1 = 7'h00; wdata0 = 8'h00; wdata1 = 8'h00; spi_rdata = 8'h00;
        repeat (3) @(negedge CLK);
        checks++;
        if ({grant, done, err, rdata, GO, spi_wr, spi_addr, spi_wdata} !== 29'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0",
                     {grant, done, err, rdata, GO, spi_wr, spi_addr, spi_wdata});
        end
        reset = 1'b1;
    endtask

    task automatic test_contention();
        @(negedge CLK);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL cont_arb_grant got %b exp 00", grant); end
        @(negedge CLK);
        checks++; if ({GO, grant} !== 3'b101) begin errors++; $display("FAIL cont_first_grant got %b exp 101", {GO, grant}); end
        @(negedge CLK);
        ORDY = 1'b1; spi_rdata = 8'h11;
        @(negedge CLK);
        ORDY = 1'b0;
        checks++; if ({done, err, rdata} !== {2'b01, 1'b0, 8'h11}) begin errors++; $display("FAIL cont_done0 got %b/%b/%h exp 01/0/11", done, err, rdata); end
        @(negedge CLK);
        checks++; if ({grant, done} !== 4'b0000) begin errors++; $display("FAIL cont_gap_grant got %b exp 0000", {grant, done}); end
        @(negedge CLK);
        @(negedge CLK);
        checks++; if ({GO, grant} !== 3'b110) begin errors++; $display("FAIL cont_second_grant got %b exp 110", {GO, grant}); end
        @(negedge CLK);
        ORDY = 1'b1; spi_rdata = 8'h22;
        @(negedge CLK);
        ORDY = 1'b0; req = 2'b00;
        checks++; if ({done, rdata} !== {2'b10, 8'h22}) begin errors++; $display("FAIL cont_done1 got %b/%h exp 10/22", done, rdata); end
        @(negedge CLK);
        checks++; if ({grant, done} !== 4'b0000) begin errors++; $display("FAIL cont_idle got %b exp 0000", {grant, done}); end
    endtask

    task automatic test_read();
        int gos = 0;
        req = 2'b01; wr = 2'b00; addr0 = 7'h2A; addr1 = 7'h11;
        @(negedge CLK);
        checks++; if ({GO, grant} !== 3'b000) begin errors++; $display("FAIL read_latency1 got %b exp 000", {GO, grant}); end
        @(negedge CLK);
        checks++;
        if ({GO, grant, spi_wr, spi_addr} !== {1'b1, 2'b01, 1'b0, 7'h2A}) begin
            errors++; $display("FAIL read_launch got %b/%b/%b/%h exp 1/01/0/2a", GO, grant, spi_wr, spi_addr);
        end
        addr0 = 7'h33;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (GO) gos++;
            checks++;
            if ({done, spi_addr} !== {2'b00, 7'h2A}) begin
                errors++; $display("FAIL read_wait cyc %0d got %b/%h exp 00/2a", i, done, spi_addr);
            end
        end
        ORDY = 1'b1; spi_rdata = 8'h5C;
        @(negedge CLK);
        ORDY = 1'b0; req = 2'b00;
        checks++;
        if ({done, err, rdata, grant} !== {2'b01, 1'b0, 8'h5C, 2'b01}) begin
            errors++; $display("FAIL read_done got %b/%b/%h/%b exp 01/0/5c/01", done, err, rdata, grant);
        end
        @(negedge CLK);
        checks++; if ({done, grant, gos} !== {2'b00, 2'b00, 32'd0}) begin errors++; $display("FAIL read_after got %b/%b extra_go %0d exp 00/00/0", done, grant, gos); end
    endtask

    task automatic test_write_drop();
        req = 2'b10; wr = 2'b10; addr1 = 7'h05; wdata1 = 8'hA5;
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if ({GO, grant, spi_wr, spi_addr, spi_wdata} !== {1'b1, 2'b10, 1'b1, 7'h05, 8'hA5}) begin
            errors++; $display("FAIL wr_launch got %b/%b/%b/%h/%h exp 1/10/1/05/a5", GO, grant, spi_wr, spi_addr, spi_wdata);
        end
        req = 2'b00; wr = 2'b00; addr1 = 7'h7F; wdata1 = 8'hFF;
        @(negedge CLK);
        checks++;
        if ({spi_wr, spi_addr, spi_wdata} !== {1'b1, 7'h05, 8'hA5}) begin
            errors++; $display("FAIL wr_hold got %b/%h/%h exp 1/05/a5", spi_wr, spi_addr, spi_wdata);
        end
        ORDY = 1'b1; spi_rdata = 8'h99;
        @(negedge CLK);
        ORDY = 1'b0;
        checks++; if ({done, err, rdata} !== {2'b10, 1'b0, 8'h00}) begin errors++; $display("FAIL wr_done got %b/%b/%h exp 10/0/00", done, err, rdata); end
        @(negedge CLK);
        checks++; if ({done, grant} !== 4'b0000) begin errors++; $display("FAIL wr_after got %b exp 0000", {done, grant}); end
    endtask

    task automatic test_stray_ordy();
        ORDY = 1'b1; spi_rdata = 8'h77;
        @(negedge CLK);
        ORDY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++;
            if ({GO, grant, done, rdata} !== 13'd0) begin
                errors++; $display("FAIL stray_ordy cyc %0d got %b/%b/%b/%h exp 0/00/00/00", i, GO, grant, done, rdata);
            end
        end
    endtask

    task automatic test_mid_reset();
        int dones = 0;
        req = 2'b01; wr = 2'b00; addr0 = 7'h2A; wdata0 = 8'h3E;
        repeat (3) @(negedge CLK);
        checks++; if ({grant, spi_addr} !== {2'b01, 7'h2A}) begin errors++; $display("FAIL mrst_wait got %b/%h exp 01/2a", grant, spi_addr); end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({grant, done, err, rdata, GO, spi_wr, spi_addr, spi_wdata} !== 29'd0) begin
            errors++; $display("FAIL mrst_async got %h exp 0", {grant, done, err, rdata, GO, spi_wr, spi_addr, spi_wdata});
        end
        req = 2'b00;
        repeat (2) @(negedge CLK);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (done != 2'b00) dones++;
        end
        checks++; if (dones != 0) begin errors++; $display("FAIL mrst_no_done got %0d pulses exp 0", dones); end
        req = 2'b10; addr1 = 7'h3C;
        repeat (2) @(negedge CLK);
        checks++; if ({GO, grant, spi_addr} !== {1'b1, 2'b10, 7'h3C}) begin errors++; $display("FAIL mrst_relaunch got %b/%b/%h exp 1/10/3c", GO, grant, spi_addr); end
        @(negedge CLK);
        ORDY = 1'b1; spi_rdata = 8'h66;
        @(negedge CLK);
        ORDY = 1'b0; req = 2'b00;
        checks++; if ({done, err, rdata} !== {2'b10, 1'b0, 8'h66}) begin errors++; $display("FAIL mrst_done got %b/%b/%h exp 10/0/66", done, err, rdata); end
    endtask

    task automatic test_timeout();
        int early = 0;
        @(negedge CLK);
        req_t = 2'b01; wr = 2'b00; addr0 = 7'h10;
        repeat (2) @(negedge CLK);
        checks++; if ({t_GO, t_grant} !== 3'b101) begin errors++; $display("FAIL to_launch got %b exp 101", {t_GO, t_grant}); end
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (t_done != 2'b00) early++;
        end
        checks++; if (early != 0) begin errors++; $display("FAIL to_early_done got %0d exp 0", early); end
        @(negedge CLK);
        req_t = 2'b10;
        checks++; if ({t_done, t_err, t_rdata} !== {2'b01, 1'b1, 8'h00}) begin errors++; $display("FAIL to_abort got %b/%b/%h exp 01/1/00", t_done, t_err, t_rdata); end
        repeat (3) @(negedge CLK);
        checks++; if ({t_GO, t_grant} !== 3'b110) begin errors++; $display("FAIL to_next_launch got %b exp 110", {t_GO, t_grant}); end
        early = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (t_done != 2'b00) early++;
        end
        ORDY = 1'b1; spi_rdata = 8'hC3;
        @(negedge CLK);
        ORDY = 1'b0; req_t = 2'b00;
        checks++; if (early != 0) begin errors++; $display("FAIL to_coinc_early got %0d exp 0", early); end
        checks++; if ({t_done, t_err, t_rdata} !== {2'b10, 1'b0, 8'hC3}) begin errors++; $display("FAIL to_coinc got %b/%b/%h exp 10/0/c3", t_done, t_err, t_rdata); end
        checks++; if (done !== 2'b00) begin errors++; $display("FAIL to_main_idle got %b exp 00", done); end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_read();
        test_write_drop();
        test_stray_ordy();
        test_mid_reset();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
